// File: rtl/light_part_table_update_if.sv
// Push and query bus of the light-part table update block: the push side carries the
// eviction stream and its almost-full flag, the query side a flow ip and its estimate.
interface light_part_table_update_if #(
    parameter int unsigned CNT_W = 8
);
    logic             ip_addr_value_in_wr;
    logic [95:0]      ip_addr_value_in;
    logic             ip_addr_value_in_alf;
    logic             query_rd;
    logic [31:0]      query_ip;
    logic             query_valid;
    logic [CNT_W-1:0] query_count;

    modport master (
        output ip_addr_value_in_wr, ip_addr_value_in, query_rd, query_ip,
        input  ip_addr_value_in_alf, query_valid, query_count
    );

    modport slave (
        input  ip_addr_value_in_wr, ip_addr_value_in, query_rd, query_ip,
        output ip_addr_value_in_alf, query_valid, query_count
    );
endinterface

// File: rtl/light_part_table_update.sv
// Folds the heavy-part eviction stream into a hashed array of saturating counters, one
// update per clock, with a 2-cycle query port. LIGHT_SAT_CNT_EN adds the sat_cnt output.
module light_part_table_update #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FIFO_AW = 9
) (
    input  logic        clk,
    input  logic        reset,
    light_part_table_update_if.slave bus,
    output logic        init_done,
    output logic [31:0] update_cnt
`ifdef LIGHT_SAT_CNT_EN
    ,
    output logic [31:0] sat_cnt
`endif
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned FDEPTH = 2 ** FIFO_AW;
    localparam int unsigned UW     = FIFO_AW + 1;
    localparam int unsigned NCHUNK = (32 + ADDR_W - 1) / ADDR_W;
    localparam logic [32:0] CNT_MAX = 33'((64'd1 << CNT_W) - 64'd1);

    typedef enum logic {INIT_S, RUN_S} state_t;

    function automatic logic [ADDR_W-1:0] hash_ip(input logic [31:0] ip);
        logic [ADDR_W-1:0] h;
        h = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            h = h ^ ADDR_W'(ip >> (k * ADDR_W));
        end
        return h;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              init_done_q, init_done_d;

    logic [63:0]        fifo_mem [FDEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]      used_q, used_d;
    logic [63:0]        fifo_rd_q;
    logic               push, pop, fifo_full, fifo_empty;
    logic [31:0]        counter_unused;

    logic [CNT_W-1:0]  cnt_mem [DEPTH];
    logic              cnt_we;
    logic [ADDR_W-1:0] cnt_widx;
    logic [CNT_W-1:0]  cnt_wdata;

    logic              p1_valid_q, p1_valid_d;
    logic [ADDR_W-1:0] p1_idx;
    logic              p2_valid_q, p2_valid_d;
    logic [ADDR_W-1:0] p2_idx_q, p2_idx_d;
    logic [31:0]       p2_value_q, p2_value_d;
    logic [CNT_W-1:0]  arr_rd_q;
    logic              fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]  fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]  p2_old;
    logic [32:0]       p2_sum;
    logic              p2_clamp;
    logic [CNT_W-1:0]  p2_new;
    logic [31:0]       update_cnt_q, update_cnt_d;
`ifdef LIGHT_SAT_CNT_EN
    logic [31:0]       sat_cnt_q, sat_cnt_d;
`endif

    logic              qv1_q, qv1_d;
    logic [ADDR_W-1:0] qidx_q, qidx_d;
    logic              query_valid_q, query_valid_d;
    logic [CNT_W-1:0]  query_count_q;

    assign counter_unused = bus.ip_addr_value_in[31:0];

    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        init_done_d   = init_done_q | (state_q == RUN_S);
        if (state_q == INIT_S) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = RUN_S;
        end

        fifo_full  = used_q[FIFO_AW];
        fifo_empty = (used_q == '0);
        push       = bus.ip_addr_value_in_wr && !fifo_full;
        pop        = (state_q == RUN_S) && !fifo_empty;
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        used_d     = used_q + UW'(push) - UW'(pop);

        p1_valid_d = pop;
        p1_idx     = hash_ip(fifo_rd_q[63:32]);
        p2_valid_d = p1_valid_q;
        p2_idx_d   = p1_idx;
        p2_value_d = fifo_rd_q[31:0];

        // A P1 read colliding with the P2 write returns stale data; take the written value next cycle.
        p2_old     = fwd_sel_q ? fwd_data_q : arr_rd_q;
        p2_sum     = 33'(p2_old) + 33'(p2_value_q);
        p2_clamp   = p2_sum > CNT_MAX;
        p2_new     = p2_clamp ? '1 : p2_sum[CNT_W-1:0];
        fwd_sel_d  = p1_valid_q && p2_valid_q && (p1_idx == p2_idx_q);
        fwd_data_d = p2_new;

        update_cnt_d = update_cnt_q + 32'(p2_valid_q);
`ifdef LIGHT_SAT_CNT_EN
        sat_cnt_d    = sat_cnt_q + 32'(p2_valid_q && p2_clamp);
`endif

        cnt_we    = !reset && ((state_q == INIT_S) || p2_valid_q);
        cnt_widx  = (state_q == INIT_S) ? sweep_q : p2_idx_q;
        cnt_wdata = (state_q == INIT_S) ? '0 : p2_new;

        qv1_d         = bus.query_rd;
        qidx_d        = hash_ip(bus.query_ip);
        query_valid_d = qv1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT_S;
            sweep_q       <= '0;
            init_done_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            used_q        <= '0;
            p1_valid_q    <= 1'b0;
            p2_valid_q    <= 1'b0;
            fwd_sel_q     <= 1'b0;
            update_cnt_q  <= '0;
`ifdef LIGHT_SAT_CNT_EN
            sat_cnt_q     <= '0;
`endif
            qv1_q         <= 1'b0;
            query_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            init_done_q   <= init_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            used_q        <= used_d;
            p1_valid_q    <= p1_valid_d;
            p2_valid_q    <= p2_valid_d;
            fwd_sel_q     <= fwd_sel_d;
            update_cnt_q  <= update_cnt_d;
`ifdef LIGHT_SAT_CNT_EN
            sat_cnt_q     <= sat_cnt_d;
`endif
            qv1_q         <= qv1_d;
            query_valid_q <= query_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        p2_idx_q   <= p2_idx_d;
        p2_value_q <= p2_value_d;
        fwd_data_q <= fwd_data_d;
        qidx_q     <= qidx_d;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.ip_addr_value_in[95:32];
        if (pop) fifo_rd_q <= fifo_mem[rd_ptr_q];
    end

    // Both read ports sample before the write lands, giving read-old-on-collision.
    always_ff @(posedge clk) begin
        arr_rd_q <= cnt_mem[p1_idx];
        if (cnt_we) cnt_mem[cnt_widx] <= cnt_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) query_count_q <= '0;
        else if (qv1_q) query_count_q <= cnt_mem[qidx_q];
    end

    assign bus.ip_addr_value_in_alf = !init_done_q || (used_q >= UW'(FDEPTH / 2));
    assign bus.query_valid          = query_valid_q;
    assign bus.query_count          = query_count_q;
    assign init_done                = init_done_q;
    assign update_cnt               = update_cnt_q;
`ifdef LIGHT_SAT_CNT_EN
    assign sat_cnt                  = sat_cnt_q;
`endif
endmodule
